lpddr2_port_arbiter: RTL and testbench
======================================

# lpddr2_port_arbiter

Two-port arbiter that shares the single `lpddr2_memory` sequencer between the CPU instruction-fetch port (port 0) and the data load/store port (port 1). It sits between the MIPS core's memory ports and `lpddr2_memory`. It latches one request at a time, drives `read_req`/`write_req`, and tracks the sequencer's `c_state` to detect acceptance and completion. On completion it returns read data and an ack pulse to the granted requester.

## Interface
- `ADDR_W`, 27, word address width (matches `lpddr2_memory`)
- `DATA_W`, 32, data width
- `MEM_IDLE`, 4'd1, `c_state` code of the sequencer idle state
- `iCLK`  in  1  sole clock; all logic rises on posedge
- `iRST_n`  in  1  reset, asynchronous, active-low
- `p0_read`, `p0_write`  in  1  port 0 request, level; held until `p0_ack`
- `p0_addr`  in  ADDR_W  port 0 address, stable while requesting
- `p0_wdata`  in  DATA_W  port 0 write data
- `p0_rdata`  out  DATA_W  port 0 read data, valid with `p0_ack`
- `p0_ack`  out  1  one-cycle completion pulse
- `p1_*`  same six signals for port 1
- `mem_read_req`, `mem_write_req`  out  1  to sequencer `read_req`/`write_req`
- `mem_addr`  out  ADDR_W  to sequencer `addr`
- `mem_wdata`  out  DATA_W  to sequencer `inData`
- `mem_rdata`  in  DATA_W  from sequencer `outData`
- `mem_state`  in  4  from sequencer `c_state`

## Operation
- States: `A_IDLE`, `A_ISSUE`, `A_BUSY`, `A_DONE`.
- A_IDLE: grant only when some port requests and `mem_state == MEM_IDLE`. On grant, latch port, op, addr and wdata into `mem_addr`/`mem_wdata`. Set `mem_read_req` or `mem_write_req`. Go to A_ISSUE.
- A_ISSUE: hold the request. When `mem_state != MEM_IDLE`, clear both request outputs and go to A_BUSY.
- A_BUSY: when `mem_state == MEM_IDLE`, capture `mem_rdata` into the granted port's `rdata` (reads only), pulse its ack, and go to A_DONE.
- A_DONE: ack low, go to A_IDLE. The next grant is made in A_IDLE.
- Read wins when a port asserts read and write together. This matches the sequencer.
- A requester dropping its request mid-operation does not abort the transfer; the ack is still issued.
- The non-granted port's `rdata` holds its previous value.
- Reset mid-operation clears the arbiter only. The sequencer has its own reset, so system reset must cover both.

## Timing
- Reset values: all request outputs 0, acks 0, `mem_addr`/`mem_wdata`/`p*_rdata` 0, state A_IDLE, `last_grant` = 1 (so port 0 wins the first tie).
- All outputs are registered.
- Example: request at edge 0 with sequencer idle.
  - `mem_*_req` goes high after edge 1.
  - Sequencer leaves idle at edge 2.
  - Request clears at edge 3.
  - Sequencer returns to idle at edge N, so ack is high for the cycle after edge N+1.
- Overhead beyond sequencer time: 3 cycles to the ack, plus 1 cycle in A_DONE before the next grant.
- Sequencer in INIT (`mem_state != MEM_IDLE`): no grant; requests wait.

## Configuration
- `LPDDR2_ARB_RR_EN` defined: round-robin. On simultaneous requests, grant the port not in `last_grant`. Update `last_grant` on every grant.
- Not defined: fixed priority, with port 1 (data) always winning. `last_grant` is not implemented.

## Structure
- Package `lpddr2_arb_pkg` holds:
  - the arbiter state enum
  - `MEM_IDLE` default
  - op encoding (`OP_READ`, `OP_WRITE`)
  - port-id typedef
- One sub-module, `lpddr2_arb_pick`: combinational grant from two request bits and `last_grant`, with the macro selecting the policy.

## Test plan
- Single read: sequencer held in INIT for 5 cycles, then idle; `p0_read`, addr 0x100, model returns 0xDEADBEEF.
  - No grant during INIT.
  - `mem_read_req` goes high one edge after idle is seen.
  - `p0_rdata` = 0xDEADBEEF with a one-cycle `p0_ack`.
- Single write: `p1_write`, addr 0x2A, data 0x12345678 -> `mem_addr` = 0x2A and `mem_wdata` = 0x12345678 while the write is issued; one `p1_ack`; `p1_rdata` unchanged.
- Simultaneous read requests from both ports, held for three transactions:
  - with `LPDDR2_ARB_RR_EN`: grant order is p0, p1, p0;
  - without it: the order is p1, p1, p1, with p0 starved while p1 holds.
- Read and write asserted together on port 0 -> only `mem_read_req` is driven.
- Request dropped while in A_BUSY -> the transfer completes and the ack still pulses once.
- `iRST_n` asserted asynchronously in A_ISSUE -> outputs clear immediately without waiting for a clock edge. After release, with the sequencer idle, a fresh request is granted normally.

Source files
------------

// File: rtl/lpddr2_arb_pkg.sv
// Shared types and constants for the LPDDR2 two-port arbiter.
// Optional feature macro: LPDDR2_ARB_RR_EN (round-robin tie breaking).
package lpddr2_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ISSUE = 2'd1,
        A_BUSY  = 2'd2,
        A_DONE  = 2'd3
    } arb_state_t;

    // c_state code of the sequencer idle state
    localparam logic [3:0] MEM_IDLE_CODE = 4'd1;

    // Latched operation of the granted request
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    // Requester identity: port 0 is instruction fetch, port 1 is load/store
    typedef logic port_id_t;
    localparam port_id_t PORT_CPU  = 1'b0;
    localparam port_id_t PORT_DATA = 1'b1;

    // Read takes precedence when a port raises read and write together,
    // mirroring the sequencer's own precedence.
    function automatic arb_op_t op_of(input logic rd);
        return rd ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/lpddr2_arb_pick.sv
// Combinational grant selection between the two requesters.
// LPDDR2_ARB_RR_EN defined: ties go to the port not granted last.
// Otherwise: fixed priority, the data port always wins.
module lpddr2_arb_pick
    import lpddr2_arb_pkg::*;
(
`ifdef LPDDR2_ARB_RR_EN
    input  port_id_t last_grant,
`endif
    input  logic     req0,
    input  logic     req1,
    output logic     any_req,
    output port_id_t grant
);

    // Pick the winning port for this cycle
    always_comb begin
        any_req = req0 | req1;
        grant   = PORT_CPU;
`ifdef LPDDR2_ARB_RR_EN
        if (req0 && req1) begin
            grant = (last_grant == PORT_CPU) ? PORT_DATA : PORT_CPU;
        end else if (req1) begin
            grant = PORT_DATA;
        end
`else
        if (req1) begin
            grant = PORT_DATA;
        end
`endif
    end

endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Two-port arbiter in front of the single lpddr2_memory sequencer.
// Latches one request at a time, drives read_req/write_req, follows the
// sequencer c_state to detect acceptance and completion, then returns
// read data and a one-cycle ack to the granted port.
// Optional feature macro: LPDDR2_ARB_RR_EN (round-robin instead of
// fixed data-port priority).
module lpddr2_port_arbiter
    import lpddr2_arb_pkg::*;
#(
    parameter int         ADDR_W   = 27,
    parameter int         DATA_W   = 32,
    parameter logic [3:0] MEM_IDLE = MEM_IDLE_CODE
) (
    input  logic              iCLK,
    input  logic              iRST_n,

    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,

    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,

    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [3:0]        mem_state
);

    arb_state_t        state_q, state_d;
    port_id_t          gnt_port_q, gnt_port_d;
    arb_op_t           gnt_op_q, gnt_op_d;

    logic              rd_req_d, wr_req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic              ack0_d, ack1_d;

    logic              req0, req1;
    logic              any_req;
    port_id_t          pick;
    logic              sel_read;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_idle;

`ifdef LPDDR2_ARB_RR_EN
    port_id_t          last_grant_q, last_grant_d;
`endif

    assign req0     = p0_read | p0_write;
    assign req1     = p1_read | p1_write;
    assign mem_idle = (mem_state == MEM_IDLE);

    lpddr2_arb_pick u_pick (
`ifdef LPDDR2_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .req0       (req0),
        .req1       (req1),
        .any_req    (any_req),
        .grant      (pick)
    );

    // Route the candidate winner's request fields toward the latch
    always_comb begin
        sel_read  = p0_read;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (pick == PORT_DATA) begin
            sel_read  = p1_read;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // Next-state and next-output logic of the transaction FSM
    always_comb begin
        state_d    = state_q;
        gnt_port_d = gnt_port_q;
        gnt_op_d   = gnt_op_q;
        rd_req_d   = mem_read_req;
        wr_req_d   = mem_write_req;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        rdata0_d   = p0_rdata;
        rdata1_d   = p1_rdata;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
`ifdef LPDDR2_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            A_IDLE: begin
                // A sequencer still in INIT or busy elsewhere holds all grants off
                if (any_req && mem_idle) begin
                    gnt_port_d = pick;
                    gnt_op_d   = op_of(sel_read);
                    rd_req_d   = sel_read;
                    wr_req_d   = ~sel_read;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
`ifdef LPDDR2_ARB_RR_EN
                    last_grant_d = pick;
`endif
                    state_d    = A_ISSUE;
                end
            end

            A_ISSUE: begin
                // The sequencer leaving idle is the acceptance handshake
                if (!mem_idle) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = A_BUSY;
                end
            end

            A_BUSY: begin
                // Return to idle marks completion; outData is valid now
                if (mem_idle) begin
                    if (gnt_port_q == PORT_DATA) begin
                        ack1_d = 1'b1;
                        if (gnt_op_q == OP_READ) begin
                            rdata1_d = mem_rdata;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        if (gnt_op_q == OP_READ) begin
                            rdata0_d = mem_rdata;
                        end
                    end
                    state_d = A_DONE;
                end
            end

            A_DONE: begin
                // One settle cycle so the requester can drop its level request
                state_d = A_IDLE;
            end

            default: begin
                state_d = A_IDLE;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q       <= A_IDLE;
            gnt_port_q    <= PORT_CPU;
            gnt_op_q      <= OP_READ;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
            p0_ack        <= 1'b0;
            p1_ack        <= 1'b0;
`ifdef LPDDR2_ARB_RR_EN
            last_grant_q  <= PORT_DATA;
`endif
        end else begin
            state_q       <= state_d;
            gnt_port_q    <= gnt_port_d;
            gnt_op_q      <= gnt_op_d;
            mem_read_req  <= rd_req_d;
            mem_write_req <= wr_req_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
            p0_rdata      <= rdata0_d;
            p1_rdata      <= rdata1_d;
            p0_ack        <= ack0_d;
            p1_ack        <= ack1_d;
`ifdef LPDDR2_ARB_RR_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed bench for lpddr2_port_arbiter with a small sequencer model.
// Expected grant order depends on LPDDR2_ARB_RR_EN.
module tb_lpddr2_port_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    logic              iCLK = 1'b0;
    logic              iRST_n;
    logic              p0_read, p0_write, p1_read, p1_write;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              p0_ack, p1_ack;
    logic              mem_read_req, mem_write_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [3:0]        mem_state;

    int total = 0;
    int bad   = 0;

    // Sequencer model: 0 = INIT, 1 = idle, 6 = busy
    logic [3:0]        seq_state = 4'd0;
    int                busy_cnt  = 0;
    bit                hold_init = 1'b1;
    logic [DATA_W-1:0] model_rdata = '0;

    assign mem_state = seq_state;
    assign mem_rdata = model_rdata;

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (hold_init) begin
            seq_state <= 4'd0;
        end else if (seq_state == 4'd0) begin
            seq_state <= 4'd1;
        end else if (seq_state == 4'd1) begin
            if (mem_read_req || mem_write_req) begin
                seq_state <= 4'd6;
                busy_cnt  <= 3;
            end
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            seq_state <= 4'd1;
        end
    end

    lpddr2_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_IDLE (4'd1)
    ) dut (
        .iCLK          (iCLK),
        .iRST_n        (iRST_n),
        .p0_read       (p0_read),
        .p0_write      (p0_write),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_rdata      (p0_rdata),
        .p0_ack        (p0_ack),
        .p1_read       (p1_read),
        .p1_write      (p1_write),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_rdata      (p1_rdata),
        .p1_ack        (p1_ack),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_state     (mem_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    // Returns 1 for a p0 ack, 2 for p1, 3 for both, 0 on timeout
    task automatic wait_ack(input int budget, output int which);
        which = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (p0_ack || p1_ack) begin
                which = {30'd0, p1_ack, p0_ack};
                break;
            end
        end
    endtask

    task automatic wait_req(input int budget, output int seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (mem_read_req || mem_write_req) begin
                seen = 1;
                break;
            end
        end
    endtask

    int                w;
    int                seen;
    int                extra;
    int                exp_order [3];
    logic [DATA_W-1:0] got;

    initial begin
`ifdef LPDDR2_ARB_RR_EN
        exp_order = '{1, 2, 1};
`else
        exp_order = '{2, 2, 2};
`endif
        iRST_n   = 1'b0;
        p0_read  = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_read  = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset state
        step(2);
        check("rst_rd_req", mem_read_req, 0);
        check("rst_wr_req", mem_write_req, 0);
        check("rst_acks", {p1_ack, p0_ack}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", {p1_rdata, p0_rdata}, 0);
        iRST_n = 1'b1;

        // Single read while the sequencer sits in INIT
        p0_read = 1'b1; p0_addr = 27'h100; model_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("init_no_grant", {mem_read_req, mem_write_req}, 0);
        end
        hold_init = 1'b0;
        step(1);
        check("idle_seen_state", mem_state, 1);
        check("idle_seen_no_req", mem_read_req, 0);
        step(1);
        check("rd_req_after_idle", mem_read_req, 1);
        check("rd_addr", mem_addr, 27'h100);
        wait_ack(20, w);
        check("rd_ack_port", w, 1);
        check("rd_data", p0_rdata, 32'hDEADBEEF);
        p0_read = 1'b0;
        step(1);
        check("rd_ack_one_cycle", p0_ack, 0);

        // Single write from the data port
        p1_write = 1'b1; p1_addr = 27'h2A; p1_wdata = 32'h12345678;
        wait_req(10, seen);
        check("wr_req_seen", seen, 1);
        check("wr_only_write", {mem_read_req, mem_write_req}, 2'b01);
        check("wr_addr", mem_addr, 27'h2A);
        check("wr_wdata", mem_wdata, 32'h12345678);
        wait_ack(20, w);
        check("wr_ack_port", w, 2);
        p1_write = 1'b0;
        check("wr_p1_rdata_held", p1_rdata, 0);
        check("wr_p0_rdata_held", p0_rdata, 32'hDEADBEEF);
        step(1);
        check("wr_ack_one_cycle", p1_ack, 0);

        // Both ports reading continuously for three transactions
        p0_read = 1'b1; p0_addr = 27'h10;
        p1_read = 1'b1; p1_addr = 27'h20;
        for (int k = 0; k < 3; k++) begin
            model_rdata = 32'hA0 + k;
            wait_ack(20, w);
            check("tie_order", w, exp_order[k]);
            got = (exp_order[k] == 2) ? p1_rdata : p0_rdata;
            check("tie_rdata", got, 32'hA0 + k);
        end
        p0_read = 1'b0; p1_read = 1'b0;

        // Read and write together on port 0
        p0_read = 1'b1; p0_write = 1'b1; p0_addr = 27'h55; p0_wdata = 32'h77;
        model_rdata = 32'hB4;
        wait_req(10, seen);
        check("rw_req_seen", seen, 1);
        check("rw_read_wins", {mem_read_req, mem_write_req}, 2'b10);
        wait_ack(20, w);
        check("rw_ack_port", w, 1);
        p0_read = 1'b0; p0_write = 1'b0;
        check("rw_rdata", p0_rdata, 32'hB4);

        // Request dropped while the sequencer is busy
        p1_read = 1'b1; p1_addr = 27'h33; model_rdata = 32'hCAFEF00D;
        wait_req(10, seen);
        check("drop_req_seen", seen, 1);
        step(2);
        check("drop_req_cleared", mem_read_req, 0);
        p1_read = 1'b0;
        wait_ack(20, w);
        check("drop_ack_port", w, 2);
        check("drop_rdata", p1_rdata, 32'hCAFEF00D);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (p0_ack || p1_ack || mem_read_req || mem_write_req) extra++;
        end
        check("drop_no_repeat", extra, 0);

        // Asynchronous reset while a write is being issued
        p0_write = 1'b1; p0_addr = 27'h66; p0_wdata = 32'h99;
        wait_req(10, seen);
        check("arst_req_seen", mem_write_req, 1);
        #2;
        iRST_n = 1'b0;
        #1;
        check("arst_wr_req", mem_write_req, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_rdata", p0_rdata, 0);
        p0_write = 1'b0;
        step(2);
        iRST_n = 1'b1;
        p0_read = 1'b1; p0_addr = 27'h123; model_rdata = 32'h5A5A5A5A;
        wait_req(10, seen);
        check("post_rst_req_seen", mem_read_req, 1);
        check("post_rst_addr", mem_addr, 27'h123);
        wait_ack(20, w);
        check("post_rst_ack_port", w, 1);
        p0_read = 1'b0;
        check("post_rst_rdata", p0_rdata, 32'h5A5A5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
